// File: rtl/uart_tx_16x_if.sv
// uart_tx_16x_if: host-side byte handshake into the UART transmitter.
// Latency: n/a (wires only); a byte transfers on any clk edge with tx_valid && tx_ready.
// Backpressure: tx_ready is low while a frame is in flight or the transmitter is disabled.
//
// Signals:
//   tx_data   byte to send (DATA_BITS wide), sampled only on the accept edge
//   tx_valid  host has a byte on tx_data
//   tx_ready  transmitter can take the byte this cycle
interface uart_tx_16x_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  // Host / TX FIFO side.
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  // Transmitter side.
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_16x.sv
// uart_tx_16x: serialises bytes into start / data / optional parity / stop bits
// for the 16x-oversampling receiver, timed by the shared 1/OVERSAMPLE baud tick.
// Latency: start bit appears on the accept edge; each bit lasts OVERSAMPLE baud ticks.
// Backpressure: tx_ready is high only in IDLE with en=1, including the tx_done cycle.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset (line forced idle-high at once)
//   baud_tick  one-clk enable per 1/OVERSAMPLE bit time
//   en         gates acceptance of new frames; a frame in flight always completes
//   bus        slave side of uart_tx_16x_if (tx_data / tx_valid / tx_ready)
//   tx         serial line, idle high, registered
//   busy       frame in progress, registered
//   tx_done    one-clk pulse in the cycle after the last stop bit ends
module uart_tx_16x #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int MSB_FIRST  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                baud_tick,
  input  logic                en,
  uart_tx_16x_if.slave        bus,
  output logic                tx,
  output logic                busy,
  output logic                tx_done
);

  // Tick counter spans one bit period; bit counter is shared between the
  // data phase (0..DATA_BITS-1) and the stop phase (0..STOP_BITS-1).
  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BMAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int BW = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic                 bit_end;
  logic                 cur_bit;
  logic [DATA_BITS-1:0] shift_adv;

  // Ready is combinational so the host sees it in the same cycle as tx_done,
  // allowing the next frame to start with no idle gap on the line.
  assign bus.tx_ready = (state_q == IDLE) && en && !rst;
  assign accept       = bus.tx_valid && bus.tx_ready;

  // A bit ends on the tick that would take the counter past OVERSAMPLE-1.
  assign bit_end = baud_tick && (tick_q == LAST_TICK);

  // The shift register only ever holds the bits still to be sent; cur_bit is
  // the next one out and shift_adv is the register after it has been consumed.
  always_comb begin
    if (MSB_FIRST != 0) begin
      cur_bit   = shift_q[DATA_BITS-1];
      shift_adv = shift_q << 1;
    end else begin
      cur_bit   = shift_q[0];
      shift_adv = shift_q >> 1;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Bit timing runs only while a frame is active.
    if ((state_q != IDLE) && baud_tick) begin
      tick_d = bit_end ? '0 : tick_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        // Counter held at zero so a tick coinciding with accept is not counted.
        tick_d = '0;
        tx_d   = 1'b1;
        if (accept) begin
          shift_d = bus.tx_data;
          par_d   = (^bus.tx_data) ^ (PARITY_ODD != 0);
          bit_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = cur_bit;
          shift_d = shift_adv;
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_q == LAST_DATA) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            tx_d    = cur_bit;
            shift_d = shift_adv;
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          if (bit_q == LAST_STOP) begin
            state_d = IDLE;
            bit_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Reset drops any partial frame; the line returns high without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_16x.sv
// tb_uart_tx_16x: directed checks of uart_tx_16x across four parameter sets
// (defaults, even parity, odd parity, two stop bits), baud_tick every 4 clk.
module tb_uart_tx_16x;

  logic clk;
  logic rst;
  logic baud_tick;
  int   bdiv;

  logic [7:0] data_a  [4];
  logic       valid_a [4];
  logic       en_a    [4];
  logic       rdy_a   [4];
  logic       tx_a    [4];
  logic       busy_a  [4];
  logic       done_a  [4];

  int total;
  int bad;

  logic cap_tx   [0:1399];
  logic cap_busy [0:1399];
  logic cap_rdy  [0:1399];
  logic cap_done [0:1399];

  uart_tx_16x_if #(.DATA_BITS(8)) if0 ();
  uart_tx_16x_if #(.DATA_BITS(8)) if1 ();
  uart_tx_16x_if #(.DATA_BITS(8)) if2 ();
  uart_tx_16x_if #(.DATA_BITS(8)) if3 ();

  assign if0.tx_data = data_a[0];  assign if0.tx_valid = valid_a[0];  assign rdy_a[0] = if0.tx_ready;
  assign if1.tx_data = data_a[1];  assign if1.tx_valid = valid_a[1];  assign rdy_a[1] = if1.tx_ready;
  assign if2.tx_data = data_a[2];  assign if2.tx_valid = valid_a[2];  assign rdy_a[2] = if2.tx_ready;
  assign if3.tx_data = data_a[3];  assign if3.tx_valid = valid_a[3];  assign rdy_a[3] = if3.tx_ready;

  uart_tx_16x u_def (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .en(en_a[0]), .bus(if0),
    .tx(tx_a[0]), .busy(busy_a[0]), .tx_done(done_a[0])
  );
  uart_tx_16x #(.PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .en(en_a[1]), .bus(if1),
    .tx(tx_a[1]), .busy(busy_a[1]), .tx_done(done_a[1])
  );
  uart_tx_16x #(.PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .en(en_a[2]), .bus(if2),
    .tx(tx_a[2]), .busy(busy_a[2]), .tx_done(done_a[2])
  );
  uart_tx_16x #(.STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .en(en_a[3]), .bus(if3),
    .tx(tx_a[3]), .busy(busy_a[3]), .tx_done(done_a[3])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to the next negedge and set baud_tick for the following posedge.
  // Outputs read after this return reflect the state after the last posedge.
  task automatic tick_clk();
    @(negedge clk);
    bdiv      = (bdiv == 3) ? 0 : bdiv + 1;
    baud_tick = (bdiv == 0);
  endtask

  // Offer a byte so that the accept edge coincides with a baud tick.
  task automatic align_offer(input int d, input logic [7:0] dat);
    do tick_clk(); while (baud_tick !== 1'b1);
    data_a[d]  = dat;
    valid_a[d] = 1'b1;
  endtask

  // Record n cycles of one DUT; index 0 is the state after the accept edge.
  task automatic capture(input int d, input int n, input logic [7:0] nd,
                         input int vdrop, input int edrop);
    for (int j = 0; j < n; j++) begin
      tick_clk();
      cap_tx[j]   = tx_a[d];
      cap_busy[j] = busy_a[d];
      cap_rdy[j]  = rdy_a[d];
      cap_done[j] = done_a[d];
      if (j == 0) data_a[d] = nd;
      if (j == vdrop) valid_a[d] = 1'b0;
      if (j == edrop) en_a[d] = 1'b0;
    end
  endtask

  task automatic test_reset();
    int done_cnt;
    int idle_bad;
    repeat (3) tick_clk();
    for (int d = 0; d < 4; d++) begin
      total++;
      if ({tx_a[d], busy_a[d], done_a[d], rdy_a[d]} !== 4'b1000) begin
        bad++;
        $display("FAIL reset_out[%0d]: tx/busy/done/rdy=%b%b%b%b want 1000",
                 d, tx_a[d], busy_a[d], done_a[d], rdy_a[d]);
      end
    end
    rst = 1'b0;
    tick_clk();
    for (int d = 0; d < 4; d++) begin
      total++;
      if (rdy_a[d] !== 1'b1) begin
        bad++;
        $display("FAIL idle_ready[%0d]: got %b want 1", d, rdy_a[d]);
      end
    end
    done_cnt = 0;
    idle_bad = 0;
    repeat (200) begin
      tick_clk();
      for (int d = 0; d < 4; d++) begin
        if (done_a[d] !== 1'b0) done_cnt++;
        if (tx_a[d] !== 1'b1 || busy_a[d] !== 1'b0) idle_bad++;
      end
    end
    total++;
    if (done_cnt != 0) begin
      bad++;
      $display("FAIL idle_done: got %0d pulses want 0", done_cnt);
    end
    total++;
    if (idle_bad != 0) begin
      bad++;
      $display("FAIL idle_line: got %0d non-idle samples want 0", idle_bad);
    end
  endtask

  task automatic test_single_frame();
    logic [11:0] exp;
    int          nd;
    int          nr;
    exp = 12'b0101001011;  // 0, A5 MSB first, 1
    align_offer(0, 8'hA5);
    capture(0, 660, 8'h00, 0, -1);
    for (int k = 0; k < 10; k++) begin
      total++;
      if (cap_tx[64*k] !== exp[9-k] || cap_tx[64*k+63] !== exp[9-k]) begin
        bad++;
        $display("FAIL a5_bit%0d: got %b..%b want %b", k, cap_tx[64*k], cap_tx[64*k+63], exp[9-k]);
      end
    end
    nd = 0;
    nr = 0;
    for (int j = 0; j < 660; j++) if (cap_done[j] === 1'b1) nd++;
    for (int j = 0; j < 640; j++) if (cap_rdy[j] !== 1'b0) nr++;
    total++;
    if (cap_done[640] !== 1'b1 || nd != 1) begin
      bad++;
      $display("FAIL a5_done: at640=%b pulses=%0d want 1 and 1", cap_done[640], nd);
    end
    total++;
    if (cap_busy[0] !== 1'b1 || cap_busy[639] !== 1'b1 || cap_busy[640] !== 1'b0) begin
      bad++;
      $display("FAIL a5_busy: got %b%b%b want 110", cap_busy[0], cap_busy[639], cap_busy[640]);
    end
    total++;
    if (nr != 0 || cap_rdy[640] !== 1'b1) begin
      bad++;
      $display("FAIL a5_ready: high_in_frame=%0d end=%b want 0 and 1", nr, cap_rdy[640]);
    end
  endtask

  task automatic test_parity();
    int          dut [4];
    logic [7:0]  dat [4];
    logic [11:0] exp [4];
    logic [11:0] e;
    dut[0] = 1; dat[0] = 8'hA5; exp[0] = 12'b01010010101;  // even parity 0
    dut[1] = 2; dat[1] = 8'hA5; exp[1] = 12'b01010010111;  // odd parity 1
    dut[2] = 1; dat[2] = 8'h01; exp[2] = 12'b00000000111;  // even parity 1
    dut[3] = 2; dat[3] = 8'h01; exp[3] = 12'b00000000101;  // odd parity 0
    for (int c = 0; c < 4; c++) begin
      e = exp[c];
      align_offer(dut[c], dat[c]);
      capture(dut[c], 720, ~dat[c], 0, -1);
      for (int k = 0; k < 11; k++) begin
        total++;
        if (cap_tx[64*k] !== e[10-k] || cap_tx[64*k+63] !== e[10-k]) begin
          bad++;
          $display("FAIL parity%0d_bit%0d: got %b..%b want %b", c, k, cap_tx[64*k], cap_tx[64*k+63], e[10-k]);
        end
      end
      total++;
      if (cap_done[703] !== 1'b0 || cap_done[704] !== 1'b1 || cap_busy[704] !== 1'b0) begin
        bad++;
        $display("FAIL parity%0d_end: done703/704=%b%b busy704=%b want 01 0",
                 c, cap_done[703], cap_done[704], cap_busy[704]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] e1;
    logic [11:0] e2;
    int          s;
    int          nr;
    int          nd;
    e1 = 12'b0001111001;  // 3C
    e2 = 12'b0110000111;  // C3
    align_offer(0, 8'h3C);
    capture(0, 1300, 8'hC3, 641, -1);
    for (int k = 0; k < 10; k++) begin
      total++;
      if (cap_tx[64*k] !== e1[9-k] || cap_tx[64*k+63] !== e1[9-k]) begin
        bad++;
        $display("FAIL b2b1_bit%0d: got %b..%b want %b", k, cap_tx[64*k], cap_tx[64*k+63], e1[9-k]);
      end
    end
    total++;
    if (cap_done[640] !== 1'b1 || cap_rdy[640] !== 1'b1 || cap_tx[640] !== 1'b1 ||
        cap_tx[641] !== 1'b0 || cap_busy[641] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_gap: done/rdy/tx@640=%b%b%b tx/busy@641=%b%b want 111 01",
               cap_done[640], cap_rdy[640], cap_tx[640], cap_tx[641], cap_busy[641]);
    end
    // Second start bit is one clk short: it begins off-tick, on the edge after tx_done.
    for (int k = 0; k < 10; k++) begin
      s = (k == 0) ? 641 : 640 + 64*k;
      total++;
      if (cap_tx[s] !== e2[9-k] || cap_tx[640+64*k+63] !== e2[9-k]) begin
        bad++;
        $display("FAIL b2b2_bit%0d: got %b..%b want %b", k, cap_tx[s], cap_tx[640+64*k+63], e2[9-k]);
      end
    end
    nr = 0;
    nd = 0;
    for (int j = 0; j < 1280; j++) if (j != 640 && cap_rdy[j] !== 1'b0) nr++;
    for (int j = 0; j < 1300; j++) if (cap_done[j] === 1'b1) nd++;
    total++;
    if (nr != 0) begin
      bad++;
      $display("FAIL b2b_ready: got %0d ready-high samples in frames want 0", nr);
    end
    total++;
    if (cap_done[1280] !== 1'b1 || nd != 2) begin
      bad++;
      $display("FAIL b2b_done: at1280=%b pulses=%0d want 1 and 2", cap_done[1280], nd);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [11:0] e;
    int          idle_bad;
    align_offer(0, 8'hFF);
    capture(0, 280, 8'hFF, 0, -1);
    total++;
    if (cap_busy[279] !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre: busy got %b want 1", cap_busy[279]);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || rdy_a[0] !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async: tx/busy/rdy=%b%b%b want 100", tx_a[0], busy_a[0], rdy_a[0]);
    end
    repeat (2) tick_clk();
    rst = 1'b0;
    idle_bad = 0;
    repeat (100) begin
      tick_clk();
      if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || done_a[0] !== 1'b0) idle_bad++;
    end
    total++;
    if (idle_bad != 0) begin
      bad++;
      $display("FAIL midrst_noresume: got %0d active samples want 0", idle_bad);
    end
    e = 12'b0010101011;  // 55
    align_offer(0, 8'h55);
    capture(0, 660, 8'h00, 0, -1);
    for (int k = 0; k < 10; k++) begin
      total++;
      if (cap_tx[64*k] !== e[9-k] || cap_tx[64*k+63] !== e[9-k]) begin
        bad++;
        $display("FAIL midrst55_bit%0d: got %b..%b want %b", k, cap_tx[64*k], cap_tx[64*k+63], e[9-k]);
      end
    end
    total++;
    if (cap_done[639] !== 1'b0 || cap_done[640] !== 1'b1) begin
      bad++;
      $display("FAIL midrst55_done: done639/640=%b%b want 01", cap_done[639], cap_done[640]);
    end
  endtask

  task automatic test_en_stop2();
    logic [11:0] e;
    int          after_bad;
    int          nr;
    e = 12'b01001011011;  // 96 with two stop bits
    align_offer(3, 8'h96);
    capture(3, 910, 8'h96, -1, 10);
    for (int k = 0; k < 11; k++) begin
      total++;
      if (cap_tx[64*k] !== e[10-k] || cap_tx[64*k+63] !== e[10-k]) begin
        bad++;
        $display("FAIL stop2_bit%0d: got %b..%b want %b", k, cap_tx[64*k], cap_tx[64*k+63], e[10-k]);
      end
    end
    total++;
    if (cap_done[640] !== 1'b0 || cap_done[704] !== 1'b1 || cap_busy[703] !== 1'b1) begin
      bad++;
      $display("FAIL stop2_done: done640/704=%b%b busy703=%b want 01 1",
               cap_done[640], cap_done[704], cap_busy[703]);
    end
    after_bad = 0;
    nr = 0;
    for (int j = 705; j < 910; j++)
      if (cap_tx[j] !== 1'b1 || cap_busy[j] !== 1'b0 || cap_done[j] !== 1'b0) after_bad++;
    for (int j = 0; j < 910; j++) if (cap_rdy[j] !== 1'b0) nr++;
    total++;
    if (after_bad != 0 || nr != 0) begin
      bad++;
      $display("FAIL en_gate: active_after=%0d ready_high=%0d want 0 and 0", after_bad, nr);
    end
    en_a[3] = 1'b1;
    #1;
    total++;
    if (rdy_a[3] !== 1'b1) begin
      bad++;
      $display("FAIL en_ready: got %b want 1", rdy_a[3]);
    end
    tick_clk();
    valid_a[3] = 1'b0;
    total++;
    if (tx_a[3] !== 1'b0 || busy_a[3] !== 1'b1) begin
      bad++;
      $display("FAIL en_accept: tx/busy=%b%b want 01", tx_a[3], busy_a[3]);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    baud_tick = 1'b0;
    bdiv      = 0;
    for (int d = 0; d < 4; d++) begin
      en_a[d]    = 1'b1;
      valid_a[d] = 1'b0;
      data_a[d]  = 8'h00;
    end
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_en_stop2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_16x.md
Name: uart_tx_16x

Overview:
UART transmitter that serialises bytes onto the line consumed by the team's 16x-oversampling receiver, which samples its data_rx input. It shares the receiver's baud tick: one enable pulse per 1/16 bit time. Parallel data arrives over a valid/ready handshake from a host or TX FIFO. The block emits start bit, data bits, optional parity, and 1 or 2 stop bits, then returns the line to idle-high.

Parameters:
DATA_BITS, 8, data bits per frame (5..8)
OVERSAMPLE, 16, baud_tick pulses per bit period
STOP_BITS, 1, stop bits per frame (1 or 2)
PARITY_EN, 0, 1 = insert parity bit after the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even parity (used only when PARITY_EN=1)
MSB_FIRST, 1, 1 = data bit DATA_BITS-1 sent first (matches receiver shift direction); 0 = LSB first

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
baud_tick  in  1  oversample enable, one-clk pulse per 1/OVERSAMPLE bit time
en  in  1  transmitter enable; gates acceptance of new frames only
tx_data  in  DATA_BITS  byte to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  block can accept a byte
tx  out  1  serial line, idle high
busy  out  1  frame in progress
tx_done  out  1  one-clk pulse at end of last stop bit

Behaviour:
- Reset takes effect immediately, mid-frame included. Reset values: tx=1, busy=0, tx_done=0, state=IDLE, tick counter=0, bit counter=0, shift register=0. The partial frame is dropped and not resumed.
- The block has five states: IDLE, START, DATA, PARITY, STOP. All outputs except tx_ready are registered.
- tx_ready is combinational: (state==IDLE) && en && !rst.
- Accept: on a clk edge with tx_valid && tx_ready:
  - latch tx_data into the shift register;
  - compute the parity bit (XOR of data, inverted if PARITY_ODD);
  - clear the tick counter, go to START, set busy=1.
  - tx goes to 0 on that same edge, with zero cycles from accept to start bit.
- In IDLE, baud_tick is ignored and the tick counter is held at 0.
- Bit timing:
  - The tick counter increments on each baud_tick while not in IDLE.
  - On a baud_tick with count==OVERSAMPLE-1, the current bit ends: the counter wraps to 0 and the next bit is driven on that edge.
  - Each bit therefore lasts exactly OVERSAMPLE baud_ticks.
- START: tx=0 for one bit period, then go to DATA with the bit counter at 0.
- DATA:
  - Bit order is MSB-first when MSB_FIRST=1, otherwise LSB-first.
  - The bit counter increments at each bit end.
  - After bit DATA_BITS-1 ends, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: drive the latched parity bit for one bit period, then go to STOP.
- STOP:
  - tx=1 for STOP_BITS bit periods.
  - At the end of the final stop bit: go to IDLE, busy=0, tx_done=1 for exactly one clk.
- Frame length is (1 + DATA_BITS + PARITY_EN + STOP_BITS) × OVERSAMPLE baud_ticks; with defaults, 160 ticks.
- Back-to-back frames:
  - tx_ready is high in the cycle tx_done is high, so the next byte can be accepted there.
  - The next start bit then follows the stop bit with no idle gap.
- If en drops mid-frame, the current frame completes normally; no new byte is accepted while en=0.
- tx_data and tx_valid changes during a frame have no effect; data is latched only at accept.
- If baud_tick is high on the accept edge, that tick is not counted; counting starts with the next tick.
- The tick counter is $clog2(OVERSAMPLE) bits wide and never exceeds OVERSAMPLE-1.

Test Plan:
- Reset then idle: rst pulse with no tx_valid, baud_tick every 4 clk -> tx=1, busy=0, tx_ready=1 with en=1; tx_done never pulses.
- Single frame, defaults, tx_data=8'hA5, baud_tick every 4 clk:
  - line per bit period is 0, 1,0,1,0,0,1,0,1, 1, each bit 16 ticks (64 clk);
  - tx_done pulses once, 640 clk after accept;
  - a loopback into the receiver yields rx_reg=8'hA5.
- Parity: PARITY_EN=1 with tx_data=8'hA5 -> parity bit 0 when PARITY_ODD=0, 1 when PARITY_ODD=1. Frame is 11 bits, 176 ticks. Repeat with 8'h01: parity 1 (even) / 0 (odd).
- Back-to-back, with tx_valid held high and data 8'h3C then 8'hC3: second start bit begins on the edge after the first frame's tx_done cycle, no idle gap. Both bytes are serialised correctly, and tx_ready is low throughout each frame.
- Reset mid-frame: assert rst during DATA bit 3 of 8'hFF -> tx=1 and busy=0 immediately, without waiting for clk. After release, a new byte 8'h55 is sent as a complete, correctly timed frame.
- en gating plus STOP_BITS=2:
  - deassert en during the start bit -> the frame completes with two 16-tick stop bits;
  - a tx_valid held high afterwards is not accepted until en=1 again.
